// File: rtl/rca_nibble_seq.sv
// Multi-nibble adder sequencer driving one shared external 4-bit ripple-carry adder.
// Optional carry-in port enabled by defining RCA_SEQ_CIN_EN.
module rca_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
`ifdef RCA_SEQ_CIN_EN
  input  logic                 cin,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 busy,
  output logic [3:0]           adder_a,
  output logic [3:0]           adder_b,
  input  logic [3:0]           adder_sum,
  input  logic                 adder_cout
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef logic [NIBBLES-1:0][3:0] nib_vec_t;

  typedef enum logic [1:0] {StIdle, StAdd, StInc, StDone} state_e;

  state_e          state_q, state_d;
  nib_vec_t        a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [3:0]      tmp_q, tmp_d;
  logic            c1_q, c1_d;
  logic            cout_q, cout_d;
  logic            init_carry;
  logic            step_done;
  logic            step_carry;

`ifdef RCA_SEQ_CIN_EN
  assign init_carry = cin;
`else
  assign init_carry = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    tmp_d       = tmp_q;
    c1_d        = c1_q;
    cout_d      = cout_q;
    step_done   = 1'b0;
    step_carry  = 1'b0;
    adder_a     = 4'h0;
    adder_b     = 4'h0;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
          carry_d = init_carry;
          state_d = StAdd;
        end
      end
      StAdd: begin
        busy    = 1'b1;
        adder_a = a_q[idx_q];
        adder_b = b_q[idx_q];
        if (!carry_q) begin
          sum_d[idx_q] = adder_sum;
          step_done    = 1'b1;
          step_carry   = adder_cout;
        end else begin
          // No carry-in on the adder: fold the incoming carry in with a +1 pass.
          tmp_d   = adder_sum;
          c1_d    = adder_cout;
          state_d = StInc;
        end
      end
      StInc: begin
        busy         = 1'b1;
        adder_a      = tmp_q;
        adder_b      = 4'h1;
        sum_d[idx_q] = adder_sum;
        step_done    = 1'b1;
        step_carry   = c1_q | adder_cout;
      end
      StDone: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (step_done) begin
      carry_d = step_carry;
      if (idx_q == IdxW'(NIBBLES - 1)) begin
        cout_d  = step_carry;
        state_d = StDone;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StAdd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      tmp_q   <= 4'h0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      tmp_q   <= tmp_d;
      c1_q    <= c1_d;
      cout_q  <= cout_d;
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Bench for rca_nibble_seq: models the external 4-bit adder and checks results,
// latency and adder traffic against an arithmetic reference model.
module tb_rca_nibble_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         busy;
  logic [3:0]   adder_a;
  logic [3:0]   adder_b;
  logic [3:0]   adder_sum;
  logic         adder_cout;

  int n_checks;
  int n_pass;

  rca_nibble_seq #(.NIBBLES(NIBBLES)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
`ifdef RCA_SEQ_CIN_EN
    .cin         (cin),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .busy        (busy),
    .adder_a     (adder_a),
    .adder_b     (adder_b),
    .adder_sum   (adder_sum),
    .adder_cout  (adder_cout)
  );

  // External rca_4bit stand-in.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One full transaction; called and returns at #1 after a rising edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int hold);
    longint unsigned mask, full, exp_sum;
    logic            eff_c, cin_i, exp_cout;
    logic [3:0]      na, nb;
    int              k, cyc, busy_cyc;
    logic [7:0]      exp_tr[$];
    logic [7:0]      trace[$];

`ifdef RCA_SEQ_CIN_EN
    eff_c = c;
`else
    eff_c = 1'b0;
`endif
    full     = longint'(a) + longint'(b) + longint'(eff_c);
    exp_sum  = full & ((64'd1 << W) - 1);
    exp_cout = full[W];
    k = 0;
    for (int i = 0; i < NIBBLES; i++) begin
      mask  = (64'd1 << (4 * i)) - 1;
      cin_i = ((((longint'(a) & mask) + (longint'(b) & mask) + eff_c) >> (4 * i)) & 1) != 0;
      na    = 4'((a >> (4 * i)) & 4'hF);
      nb    = 4'((b >> (4 * i)) & 4'hF);
      exp_tr.push_back({na, nb});
      if (cin_i) begin
        k++;
        exp_tr.push_back({4'(na + nb), 4'h1});
      end
    end

    check("idle_ready", start_ready, 1);
    op_a = a; op_b = b; cin = c; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; cin = $urandom;

    cyc = 0; busy_cyc = 0;
    while (!res_valid && cyc < 60) begin
      if (busy) begin
        busy_cyc++;
        trace.push_back({adder_a, adder_b});
      end
      check("busy_no_ready", start_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, NIBBLES + k);
    check("busy_cycles", busy_cyc, NIBBLES + k);
    check("trace_len", trace.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
      check($sformatf("adder_ab[%0d]", i), trace[i], exp_tr[i]);
    check("sum", res_sum, 32'(exp_sum));
    check("cout", res_cout, exp_cout);
    check("done_adder", {adder_a, adder_b}, 0);

    // Backpressure with a competing request that must be ignored.
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_sum", res_sum, 32'(exp_sum));
      check("hold_cout", res_cout, exp_cout);
      check("hold_ready", start_ready, 0);
      check("hold_busy", busy, 0);
    end

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start_valid = 1'b0;
    check("release_valid", res_valid, 0);
    check("release_ready", start_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    logic seen;
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", start_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_cout", res_cout, 0);
    check("rst_busy", busy, 0);
    check("rst_adder", {adder_a, adder_b}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0000, 16'h0000, 1'b0, 0);
    run_op(16'h1234, 16'h0001, 1'b0, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
`ifdef RCA_SEQ_CIN_EN
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
`endif
    run_op(16'h8421, 16'h7BDF, 1'b0, 5);
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 0);

    // Reset in the 2nd ADD cycle abandons the operation.
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", start_ready, 1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_sum", res_sum, 0);
    check("mid_rst_adder", {adder_a, adder_b}, 0);
    check("mid_rst_busy", busy, 0);
    seen = 1'b0;
    res_ready = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 0);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = (t % 3 == 0) ? W'(~a + W'($urandom_range(0, 3))) : W'($urandom);
      run_op(a, b, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
